// File: rtl/sys_bus_initiator.sv
// Single-outstanding system-bus master: command in, one strobe out, response back.
// Latency: strobe one cycle after accept; response one cycle after ack/err or timeout.
// Backpressure: cmd_ready_o is low while a transaction or unconsumed response is pending.
module sys_bus_initiator #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8,
  parameter int CW      = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  // command channel
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [31:0]   cmd_addr_i,
  input  logic [31:0]   cmd_wdata_i,
  input  logic [3:0]    cmd_sel_i,
  // response channel
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          rsp_timeout_o,
  // system bus
  output logic [31:0]   sys_addr_o,
  output logic [31:0]   sys_wdata_o,
  output logic [3:0]    sys_sel_o,
  output logic          sys_wen_o,
  output logic          sys_ren_o,
  input  logic [31:0]   sys_rdata_i,
  input  logic          sys_err_i,
  input  logic          sys_ack_i,
  // status
  output logic          busy_o,
  output logic [CW-1:0] txn_cnt_o,
  output logic [CW-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Timer value in the last cycle we are willing to wait for ack/err.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            busy_q, busy_d;
  logic            we_q, we_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      sel_q, sel_d;
  logic            wen_q, wen_d;
  logic            ren_q, ren_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_tmo_q, rsp_tmo_d;
  logic [CW-1:0]   txn_cnt_q, txn_cnt_d;
  logic [CW-1:0]   err_cnt_q, err_cnt_d;

  logic            bus_done;

  // ack and err both end the bus cycle; err wins over ack when both are high.
  assign bus_done = sys_ack_i | sys_err_i;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    we_d        = we_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    txn_cnt_d   = txn_cnt_q;
    err_cnt_d   = err_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          addr_d      = cmd_addr_i;
          wdata_d     = cmd_wdata_i;
          sel_d       = cmd_sel_i;
          we_d        = cmd_we_i;
          wen_d       = cmd_we_i;
          ren_d       = ~cmd_we_i;
          timer_d     = '0;
          cmd_ready_d = 1'b0;
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE, ST_WAIT: begin
        if (bus_done) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = sys_err_i;
          rsp_tmo_d   = 1'b0;
          rsp_rdata_d = (!we_q && !sys_err_i) ? sys_rdata_i : 32'h0;
          state_d     = ST_RESP;
        end else if (timer_q == TMO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          rsp_rdata_d = 32'h0;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
          state_d = ST_WAIT;
        end
      end

      ST_RESP: begin
        // Bus inputs are deliberately ignored here; only the consumer moves us on.
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          txn_cnt_d   = txn_cnt_q + CW'(1);
          if (rsp_err_q) begin
            err_cnt_d = err_cnt_q + CW'(1);
          end
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any pending transaction silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      we_q        <= 1'b0;
      timer_q     <= '0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      sel_q       <= 4'h0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      txn_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      we_q        <= we_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      txn_cnt_q   <= txn_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign busy_o        = busy_q;
  assign sys_addr_o    = addr_q;
  assign sys_wdata_o   = wdata_q;
  assign sys_sel_o     = sel_q;
  assign sys_wen_o     = wen_q;
  assign sys_ren_o     = ren_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_tmo_q;
  assign txn_cnt_o     = txn_cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_sys_bus_initiator.sv
// Directed bench for sys_bus_initiator with TIMEOUT=16 and 4-bit counters.
module tb_sys_bus_initiator;

  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0]   cmd_addr_i, cmd_wdata_i;
  logic [3:0]    cmd_sel_i;
  logic          rsp_valid_o, rsp_ready_i;
  logic [31:0]   rsp_rdata_o;
  logic          rsp_err_o, rsp_timeout_o;
  logic [31:0]   sys_addr_o, sys_wdata_o;
  logic [3:0]    sys_sel_o;
  logic          sys_wen_o, sys_ren_o;
  logic [31:0]   sys_rdata_i;
  logic          sys_err_i, sys_ack_i;
  logic          busy_o;
  logic [CW-1:0] txn_cnt_o, err_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [CW-1:0] exp_txn = '0;
  logic [CW-1:0] exp_err = '0;

  sys_bus_initiator #(.TIMEOUT(16), .TW(8), .CW(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_sel_o(sys_sel_o),
    .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o), .sys_rdata_i(sys_rdata_i),
    .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i),
    .busy_o(busy_o), .txn_cnt_o(txn_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance into the next cycle; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_cmd(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] sel);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_sel_i   = sel;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = 0; cmd_wdata_i = 0; cmd_sel_i = 0;
    rsp_ready_i = 0; sys_rdata_i = 0; sys_err_i = 0; sys_ack_i = 0;
    step(); step();
    n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_o); end
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, sys_wen_o, sys_ren_o, busy_o} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000", {rsp_valid_o, rsp_err_o, rsp_timeout_o, sys_wen_o, sys_ren_o, busy_o}); end
    n_cmp++; if ({sys_addr_o, sys_wdata_o, sys_sel_o, rsp_rdata_o} !== 100'h0) begin
      n_bad++; $display("FAIL reset_data: got %h %h %h %h want zeros", sys_addr_o, sys_wdata_o, sys_sel_o, rsp_rdata_o); end
    n_cmp++; if ({txn_cnt_o, err_cnt_o} !== 8'h0) begin n_bad++; $display("FAIL reset_cnt: got %h %h want 0 0", txn_cnt_o, err_cnt_o); end
    #2 rst_i = 1'b0;
    step();
  endtask

  // Read, responder acks in C2.
  task automatic test_read();
    drive_cmd(1'b0, 32'h4000_0000, 32'h0, 4'hF);                  // C0
    step(); cmd_valid_i = 0;                                       // C1
    n_cmp++; if ({sys_ren_o, sys_wen_o, cmd_ready_o, busy_o} !== 4'b1001) begin
      n_bad++; $display("FAIL read_c1_strobe: got ren/wen/rdy/busy %b want 1001", {sys_ren_o, sys_wen_o, cmd_ready_o, busy_o}); end
    n_cmp++; if (sys_addr_o !== 32'h4000_0000) begin n_bad++; $display("FAIL read_c1_addr: got %h want 40000000", sys_addr_o); end
    step(); sys_ack_i = 1; sys_rdata_i = 32'h1;                    // C2
    n_cmp++; if ({sys_ren_o, rsp_valid_o} !== 2'b00 || sys_addr_o !== 32'h4000_0000) begin
      n_bad++; $display("FAIL read_c2: got ren %b rspv %b addr %h want 0 0 40000000", sys_ren_o, rsp_valid_o, sys_addr_o); end
    step(); sys_ack_i = 0; sys_rdata_i = 0; rsp_ready_i = 1;       // C3
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b100 || rsp_rdata_o !== 32'h1) begin
      n_bad++; $display("FAIL read_rsp: got v/e/t %b rdata %h want 100 00000001", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, rsp_rdata_o); end
    step(); rsp_ready_i = 0; exp_txn++;
    n_cmp++; if ({rsp_valid_o, cmd_ready_o, busy_o} !== 3'b010 || txn_cnt_o !== exp_txn) begin
      n_bad++; $display("FAIL read_done: got v/rdy/busy %b txn %0d want 010 %0d", {rsp_valid_o, cmd_ready_o, busy_o}, txn_cnt_o, exp_txn); end
  endtask

  task automatic test_write();
    drive_cmd(1'b1, 32'h30, 32'hA5, 4'hF);
    step(); cmd_valid_i = 0;                                       // C1
    n_cmp++; if ({sys_wen_o, sys_ren_o} !== 2'b10 || sys_wdata_o !== 32'hA5 || sys_sel_o !== 4'hF) begin
      n_bad++; $display("FAIL write_c1: got wen/ren %b wdata %h sel %h want 10 a5 f", {sys_wen_o, sys_ren_o}, sys_wdata_o, sys_sel_o); end
    step(); sys_ack_i = 1; sys_rdata_i = 32'h1234_5678;            // C2
    n_cmp++; if ({sys_wen_o, sys_ren_o} !== 2'b00 || sys_wdata_o !== 32'hA5 || sys_addr_o !== 32'h30) begin
      n_bad++; $display("FAIL write_c2: got wen/ren %b wdata %h addr %h want 00 a5 30", {sys_wen_o, sys_ren_o}, sys_wdata_o, sys_addr_o); end
    step(); sys_ack_i = 0; rsp_ready_i = 1;                        // C3
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b100 || rsp_rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL write_rsp: got v/e/t %b rdata %h want 100 0", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, rsp_rdata_o); end
    step(); rsp_ready_i = 0; exp_txn++;
    n_cmp++; if (sys_addr_o !== 32'h30 || sys_wdata_o !== 32'hA5 || txn_cnt_o !== exp_txn) begin
      n_bad++; $display("FAIL write_hold: got addr %h wdata %h txn %0d want 30 a5 %0d", sys_addr_o, sys_wdata_o, txn_cnt_o, exp_txn); end
  endtask

  task automatic test_timeout();
    drive_cmd(1'b0, 32'h88, 32'h0, 4'h1);
    step(); cmd_valid_i = 0;                                       // C1
    for (int c = 2; c <= 16; c++) step();                          // now C16
    n_cmp++; if (rsp_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      n_bad++; $display("FAIL tmo_early: got rspv %b busy %b in C16 want 0 1", rsp_valid_o, busy_o); end
    step();                                                        // C17
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b111 || rsp_rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL tmo_rsp: got v/e/t %b rdata %h want 111 0", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, rsp_rdata_o); end
    rsp_ready_i = 1; step(); rsp_ready_i = 0; exp_txn++; exp_err++;
    n_cmp++; if (txn_cnt_o !== exp_txn || err_cnt_o !== exp_err) begin
      n_bad++; $display("FAIL tmo_cnt: got txn %0d err %0d want %0d %0d", txn_cnt_o, err_cnt_o, exp_txn, exp_err); end
  endtask

  task automatic test_ack_err();
    drive_cmd(1'b0, 32'h44, 32'h0, 4'hF);
    step(); cmd_valid_i = 0;
    step(); sys_ack_i = 1; sys_err_i = 1; sys_rdata_i = 32'hDEAD_BEEF;
    step(); sys_ack_i = 0; sys_err_i = 0; sys_rdata_i = 0;
    n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o} !== 3'b110 || rsp_rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL ackerr_rsp: got v/e/t %b rdata %h want 110 0", {rsp_valid_o, rsp_err_o, rsp_timeout_o}, rsp_rdata_o); end
    rsp_ready_i = 1; step(); rsp_ready_i = 0; exp_txn++; exp_err++;
    n_cmp++; if (txn_cnt_o !== exp_txn || err_cnt_o !== exp_err) begin
      n_bad++; $display("FAIL ackerr_cnt: got txn %0d err %0d want %0d %0d", txn_cnt_o, err_cnt_o, exp_txn, exp_err); end
  endtask

  // Minimum-latency read, then a held response with a queued second command.
  task automatic test_backpressure();
    drive_cmd(1'b0, 32'h100, 32'h0, 4'hF);
    step(); drive_cmd(1'b1, 32'h200, 32'h55, 4'h3);                // C1, ack now
    sys_ack_i = 1; sys_rdata_i = 32'h11;
    step(); sys_ack_i = 0; sys_rdata_i = 0;                        // C2
    n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h11) begin
      n_bad++; $display("FAIL bp_minlat: got rspv %b rdata %h in C2 want 1 11", rsp_valid_o, rsp_rdata_o); end
    for (int k = 0; k < 5; k++) begin
      sys_ack_i = k[0]; sys_err_i = k[0]; sys_rdata_i = 32'hFFFF_0000;
      step();
      n_cmp++; if ({rsp_valid_o, rsp_err_o, rsp_timeout_o, cmd_ready_o, sys_wen_o, sys_ren_o} !== 6'b100000 || rsp_rdata_o !== 32'h11) begin
        n_bad++; $display("FAIL bp_hold%0d: got v/e/t/rdy/wen/ren %b rdata %h want 100000 11", k, {rsp_valid_o, rsp_err_o, rsp_timeout_o, cmd_ready_o, sys_wen_o, sys_ren_o}, rsp_rdata_o); end
    end
    sys_ack_i = 0; sys_err_i = 0; sys_rdata_i = 0;
    rsp_ready_i = 1; step(); rsp_ready_i = 0; exp_txn++;           // IDLE, second cmd accepted at next edge
    n_cmp++; if ({rsp_valid_o, cmd_ready_o, sys_wen_o} !== 3'b010 || txn_cnt_o !== exp_txn || err_cnt_o !== exp_err) begin
      n_bad++; $display("FAIL bp_release: got v/rdy/wen %b txn %0d err %0d want 010 %0d %0d", {rsp_valid_o, cmd_ready_o, sys_wen_o}, txn_cnt_o, err_cnt_o, exp_txn, exp_err); end
    step(); cmd_valid_i = 0; sys_ack_i = 1;                        // ISSUE of second cmd
    n_cmp++; if ({sys_wen_o, sys_ren_o, cmd_ready_o} !== 3'b100 || sys_addr_o !== 32'h200 || sys_wdata_o !== 32'h55 || sys_sel_o !== 4'h3) begin
      n_bad++; $display("FAIL bp_second: got wen/ren/rdy %b addr %h wdata %h sel %h want 100 200 55 3", {sys_wen_o, sys_ren_o, cmd_ready_o}, sys_addr_o, sys_wdata_o, sys_sel_o); end
    step(); sys_ack_i = 0; rsp_ready_i = 1;
    n_cmp++; if ({rsp_valid_o, rsp_err_o} !== 2'b10 || rsp_rdata_o !== 32'h0) begin
      n_bad++; $display("FAIL bp_second_rsp: got v/e %b rdata %h want 10 0", {rsp_valid_o, rsp_err_o}, rsp_rdata_o); end
    step(); rsp_ready_i = 0; exp_txn++;
  endtask

  // Twelve writes at full rate; the 4-bit counters wrap along the way.
  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      n_cmp++; if (cmd_ready_o !== 1'b1) begin n_bad++; $display("FAIL b2b_ready%0d: got %b want 1", i, cmd_ready_o); end
      drive_cmd(1'b1, 32'h1000 + 32'(i), 32'(i), 4'hF);
      step(); cmd_valid_i = 0;
      step(); sys_ack_i = 1;
      step(); sys_ack_i = 0; rsp_ready_i = 1;
      step(); rsp_ready_i = 0; exp_txn++;
    end
    n_cmp++; if (txn_cnt_o !== exp_txn || err_cnt_o !== exp_err || exp_txn !== 4'd2) begin
      n_bad++; $display("FAIL b2b_wrap: got txn %0d err %0d want %0d %0d (model txn 2)", txn_cnt_o, err_cnt_o, exp_txn, exp_err); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    drive_cmd(1'b0, 32'h500, 32'h0, 4'hF);
    step(); cmd_valid_i = 0;
    step(); step();                                                // in WAIT
    #2 rst_i = 1'b1;
    #1;
    n_cmp++; if ({sys_ren_o, sys_wen_o, rsp_valid_o, busy_o, cmd_ready_o} !== 5'b00001 || {txn_cnt_o, err_cnt_o} !== 8'h0 || sys_addr_o !== 32'h0) begin
      n_bad++; $display("FAIL rstmid: got ren/wen/v/busy/rdy %b cnt %h %h addr %h want 00001 0 0 0", {sys_ren_o, sys_wen_o, rsp_valid_o, busy_o, cmd_ready_o}, txn_cnt_o, err_cnt_o, sys_addr_o); end
    #2 rst_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      sys_ack_i = c[1]; sys_rdata_i = 32'h77;
      step();
      if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) seen = 1'b1;
    end
    sys_ack_i = 0; sys_rdata_i = 0;
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet: got activity %b want 0", seen); end
    exp_txn = '0; exp_err = '0;
    drive_cmd(1'b0, 32'h600, 32'h0, 4'hF);
    step(); cmd_valid_i = 0; sys_ack_i = 1; sys_rdata_i = 32'hCAFE;
    step(); sys_ack_i = 0; rsp_ready_i = 1;
    n_cmp++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hCAFE) begin
      n_bad++; $display("FAIL rstmid_resume: got v %b rdata %h want 1 cafe", rsp_valid_o, rsp_rdata_o); end
    step(); rsp_ready_i = 0; exp_txn++;
    n_cmp++; if (txn_cnt_o !== exp_txn) begin n_bad++; $display("FAIL rstmid_cnt: got %0d want %0d", txn_cnt_o, exp_txn); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_ack_err();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sys_bus_initiator.md
Name: sys_bus_initiator

Overview:
- Single-outstanding master for the system bus. It takes a command over a valid/ready handshake and drives one read or write strobe to the bus responders (housekeeping, scope, generator, ...).
- It waits for ack/err or a timeout, then returns the response over a second valid/ready handshake.
- It is used by on-chip sequencers and by bench stimulus to reach register banks without the PS.
- It keeps transaction and error counters for debug.

Parameters:
- TIMEOUT, 255: cycles to wait for sys_ack_i/sys_err_i, counted from the strobe cycle. Must be >= 2.
- TW, 8: width of the timeout counter. Must satisfy 2^TW > TIMEOUT.
- CW, 16: width of the statistics counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when high together with valid
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  32  bus address
- cmd_wdata_i  in  32  write data
- cmd_sel_i  in  4  byte select
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data; 0 for writes, errors and timeouts
- rsp_err_o  out  1  responder error or timeout
- rsp_timeout_o  out  1  no ack/err within TIMEOUT
- sys_addr_o  out  32  bus address
- sys_wdata_o  out  32  bus write data
- sys_sel_o  out  4  bus byte select
- sys_wen_o  out  1  write strobe, one cycle
- sys_ren_o  out  1  read strobe, one cycle
- sys_rdata_i  in  32  bus read data
- sys_err_i  in  1  bus error
- sys_ack_i  in  1  bus acknowledge
- busy_o  out  1  high in any state other than IDLE
- txn_cnt_o  out  CW  completed transactions
- err_cnt_o  out  CW  completed transactions with rsp_err_o = 1

Behaviour:
- Clock and reset: clk_i with rst_i, asynchronous active-high reset. All outputs are registered.
- Reset values:
  - state IDLE, cmd_ready_o = 1, all other outputs 0.
  - sys_addr_o, sys_wdata_o, sys_sel_o = 0.
  - counters = 0.
- Reset asserted mid-operation:
  - Outputs go to reset values immediately, including strobes.
  - The pending transaction is dropped with no response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i & cmd_ready_o in cycle C0: latch addr/wdata/sel into sys_*_o and clear the timer. Go to ISSUE.
  - Outputs update at the C0/C1 edge; cmd_ready_o drops in C1.
- ISSUE (cycle C1):
  - Exactly one of sys_wen_o (we=1) or sys_ren_o (we=0) is high, for this single cycle.
  - sys_ack_i/sys_err_i are sampled in this cycle too.
  - Next state is WAIT, unless ack/err is seen or TIMEOUT is reached.
- WAIT:
  - Strobes are low; sys_addr_o/wdata_o/sel_o are held stable.
  - The timer increments each cycle in ISSUE/WAIT without ack/err.
- Completion, leaving ISSUE or WAIT; the response registers are loaded on that edge:
  - On sys_ack_i | sys_err_i: rsp_err_o = sys_err_i, rsp_timeout_o = 0, rsp_rdata_o = sys_rdata_i for reads (0 for writes or when sys_err_i = 1). Go to RESP.
  - If ack and err are both high: treated as error.
  - If the timer reaches TIMEOUT-1 with no ack/err in that cycle: rsp_err_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0. Go to RESP. Result: with no ack, rsp_valid_o first rises in cycle C1+TIMEOUT.
- RESP:
  - rsp_valid_o = 1; rsp_* outputs stay stable until rsp_valid_o & rsp_ready_i.
  - On that handshake: txn_cnt_o += 1; err_cnt_o += 1 if rsp_err_o. Then rsp_valid_o = 0, go to IDLE, cmd_ready_o = 1 in the next cycle.
- Latency with a responder that acks one cycle after the strobe:
  - Strobe in C1, ack in C2, rsp_valid_o high from C3.
  - Minimum latency (ack during C1): rsp_valid_o from C2.
  - Back-to-back throughput: one command per 4 cycles.
- Stray inputs: sys_ack_i/sys_err_i in IDLE or RESP are ignored. Only one command is ever outstanding.
- Counters wrap from 2^CW-1 to 0.
- sys_*_o keep the last command's values after completion until the next accept.

Test Plan:
1. Read cmd addr 0x40000000, responder acks in C2 with rdata 0x00000001 -> sys_ren_o high only in C1; sys_addr_o = 0x40000000 C1-C2; rsp_valid_o from C3, rdata 0x00000001, err 0, timeout 0; txn_cnt_o = 1.
2. Write cmd addr 0x30, wdata 0x000000A5, sel 0xF, ack in C2 -> sys_wen_o high only in C1, sys_ren_o never high; rsp rdata 0x0, err 0; wdata stable through C2.
3. TIMEOUT = 16, no ack -> rsp_valid_o from C17, err 1, timeout 1, rdata 0; err_cnt_o = 1, txn_cnt_o = 1.
4. Responder returns ack + err + rdata 0xDEADBEEF on a read -> rsp err 1, timeout 0, rdata 0x0; err_cnt_o increments.
5. Backpressure: rsp_ready_i low 5 cycles while cmd_valid_i stays high with a second cmd, stray ack injected during RESP -> rsp fields unchanged, cmd_ready_o low, no strobe; second cmd accepted the cycle after rsp_ready_i rises; its strobe follows one cycle later.
6. Assert rst_i in WAIT -> sys_ren_o/sys_wen_o 0, rsp_valid_o 0, busy_o 0 immediately; counters 0; after release cmd_ready_o = 1 and no response ever appears for the dropped cmd.
